// File: rtl/pzcorebus_error_responder.sv
// Error responder: absorbs any command, drains write data, and answers every
// non-posted command with error responses (read bursts get one beat per beat).
module pzcorebus_error_responder #(
  parameter int ID_WIDTH     = 8,
  parameter int LENGTH_WIDTH = 5,
  parameter int DATA_WIDTH   = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_mcmd_valid,
  output logic                    o_mcmd_accept,
  input  logic [1:0]              i_mcmd,
  input  logic [ID_WIDTH-1:0]     i_mid,
  input  logic [LENGTH_WIDTH-1:0] i_mlength,
  input  logic                    i_mdata_valid,
  output logic                    o_mdata_accept,
  input  logic                    i_mdata_last,
  output logic                    o_sresp_valid,
  input  logic                    i_mresp_accept,
  output logic                    o_sresp,
  output logic [ID_WIDTH-1:0]     o_sid,
  output logic                    o_serror,
  output logic [DATA_WIDTH-1:0]   o_sdata,
  output logic                    o_slast,
  output logic [1:0]              o_state
);

  // Handshakes: a transfer happens on a rising edge where valid and
  // accept/ready are both high; valid never waits on accept, and the
  // response payload is held unchanged until its transfer completes.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDRAIN = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] CMD_READ   = 2'd0;
  localparam logic [1:0] CMD_POSTED = 2'd2;

  localparam logic [LENGTH_WIDTH:0] ONE     = {{LENGTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [LENGTH_WIDTH:0] MAX_LEN = {1'b1, {LENGTH_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  read_q, read_d;
  logic                  posted_q, posted_d;
  logic [LENGTH_WIDTH:0] len_q, len_d;
  logic [LENGTH_WIDTH:0] cnt_q, cnt_d;

  logic [LENGTH_WIDTH:0] cmd_len;
  logic [LENGTH_WIDTH:0] cnt_inc;
  logic                  final_beat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      id_q     <= '0;
      read_q   <= 1'b0;
      posted_q <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      read_q   <= read_d;
      posted_q <= posted_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    read_d         = read_q;
    posted_d       = posted_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    o_mcmd_accept  = 1'b0;
    o_mdata_accept = 1'b0;
    o_sresp_valid  = 1'b0;
    o_sresp        = 1'b0;
    o_sid          = '0;
    o_serror       = 1'b0;
    o_slast        = 1'b0;

    // A zero length field stands for the largest burst, hence the extra bit.
    cmd_len    = (i_mlength == '0) ? MAX_LEN : {1'b0, i_mlength};
    cnt_inc    = cnt_q + ONE;
    final_beat = read_q ? (cnt_inc == len_q) : 1'b1;

    case (state_q)
      IDLE: begin
        o_mcmd_accept = ~i_rst;
        if (i_mcmd_valid && o_mcmd_accept) begin
          id_d     = i_mid;
          len_d    = cmd_len;
          read_d   = (i_mcmd == CMD_READ);
          posted_d = (i_mcmd == CMD_POSTED);
          cnt_d    = '0;
          state_d  = (i_mcmd == CMD_READ) ? RESP : WDRAIN;
        end
      end
      WDRAIN: begin
        o_mdata_accept = ~i_rst;
        if (i_mdata_valid && o_mdata_accept) begin
          if (i_mdata_last || (cnt_inc == len_q)) begin
            cnt_d   = '0;
            state_d = posted_q ? IDLE : RESP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      RESP: begin
        // Outputs are forced low while reset is asserted so a dropped burst
        // never shows another beat.
        if (!i_rst) begin
          o_sresp_valid = 1'b1;
          o_sresp       = read_q;
          o_sid         = id_q;
          o_serror      = 1'b1;
          o_slast       = final_beat;
        end
        if (o_sresp_valid && i_mresp_accept) begin
          if (final_beat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_sdata = '0;
  assign o_state = state_q;

endmodule

// File: doc/pzcorebus_error_responder.md
PZCOREBUS_ERROR_RESPONDER -- requirements
Module: pzcorebus_error_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 8, meaning width of mid/sid.
REQ-002 SHALL have parameter LENGTH_WIDTH, default 5, meaning burst length field width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, meaning sdata width.
REQ-004 SHALL have port i_clk  in  1  clock, single clock domain.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_mcmd_valid  in  1  command valid.
REQ-007 SHALL have port o_mcmd_accept  out  1  command accept.
REQ-008 SHALL have port i_mcmd  in  2  command type: 0 READ, 1 WRITE (non-posted), 2 POSTED_WRITE, 3 reserved.
REQ-009 SHALL have port i_mid  in  ID_WIDTH  command ID.
REQ-010 SHALL have port i_mlength  in  LENGTH_WIDTH  burst length in beats; 0 encodes 2^LENGTH_WIDTH.
REQ-011 SHALL have port i_mdata_valid  in  1  write data valid.
REQ-012 SHALL have port o_mdata_accept  out  1  write data accept.
REQ-013 SHALL have port i_mdata_last  in  1  last write beat marker.
REQ-014 SHALL have port o_sresp_valid  out  1  response valid.
REQ-015 SHALL have port i_mresp_accept  in  1  response accept from downstream response master.
REQ-016 SHALL have port o_sresp  out  1  0 RESPONSE, 1 RESPONSE_WITH_DATA.
REQ-017 SHALL have port o_sid  out  ID_WIDTH  response ID.
REQ-018 SHALL have port o_serror  out  1  error flag.
REQ-019 SHALL have port o_sdata  out  DATA_WIDTH  response data.
REQ-020 SHALL have port o_slast  out  1  last response beat.

Function
REQ-021 SHALL implement FSM states IDLE, WDRAIN, RESP; one command in flight.
REQ-022 SHALL drive o_mcmd_accept=1 only in IDLE; command transfer = i_mcmd_valid & o_mcmd_accept.
REQ-023 SHALL on READ transfer latch i_mid and length (0 -> 2^LENGTH_WIDTH, counter width LENGTH_WIDTH+1), go to RESP next cycle.
REQ-024 SHALL on WRITE or POSTED_WRITE transfer latch ID/type/length, go to WDRAIN.
REQ-025 SHALL treat reserved i_mcmd=3 as WRITE.
REQ-026 SHALL drive o_mdata_accept=1 only in WDRAIN; data beats in IDLE/RESP not accepted.
REQ-027 SHALL leave WDRAIN after the beat where i_mdata_last=1 or the beat count reaches latched length, whichever first; WRITE -> RESP, POSTED_WRITE -> IDLE.
REQ-028 SHALL in RESP assert o_sresp_valid=1, o_sid=latched ID, o_serror=1, o_sdata=0.
REQ-029 SHALL for READ emit exactly length beats with o_sresp=1, o_slast=1 only on final beat.
REQ-030 SHALL for WRITE emit one beat with o_sresp=0, o_slast=1.
REQ-031 SHALL hold all response outputs stable while o_sresp_valid=1 and i_mresp_accept=0.
REQ-032 SHALL advance beat only on o_sresp_valid & i_mresp_accept; after final accepted beat return to IDLE, accepting a new command no earlier than the following cycle.
REQ-033 SHALL have minimum latency one cycle from command accept to first response valid (READ) and one cycle from last data accept to response valid (WRITE).
REQ-034 SHALL drive o_sresp_valid=0, o_slast=0, o_serror=0, o_sresp=0, o_sid=0 outside RESP.

Reset
REQ-035 SHALL on i_rst=1 at a rising i_clk enter IDLE, clear counters and latched fields, regardless of state.
REQ-036 SHALL during and after reset cycle drive o_mcmd_accept=0 while i_rst=1, o_mdata_accept=0, o_sresp_valid=0, all other outputs 0.
REQ-037 SHALL on reset mid-burst drop the pending burst without emitting further beats.

Verification
REQ-038 SHALL pass: READ mid=0x12 mlength=4, accept always 1 -> 4 beats sid=0x12 serror=1 sresp=1, slast on 4th, mcmd_accept back to 1 one cycle later.
REQ-039 SHALL pass: WRITE mid=0x3 mlength=2, two data beats last on 2nd -> one beat sresp=0 serror=1 slast=1 sid=0x3.
REQ-040 SHALL pass: POSTED_WRITE mlength=3 with 3 data beats -> no response, IDLE after 3rd beat.
REQ-041 SHALL pass: READ mlength=0 (LENGTH_WIDTH=5) -> 32 beats, slast only on 32nd.
REQ-042 SHALL pass: READ mlength=3 with i_mresp_accept toggling 0/1 -> outputs stable during stalls, exactly 3 accepted beats.
REQ-043 SHALL pass: i_rst=1 during 2nd beat of READ mlength=8 -> o_sresp_valid=0 next cycle, IDLE, next READ served normally.
